// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the shift-add multiplier.
// The slave side is the multiplier. The master side is whoever issues loads
// and consumes the product and observation outputs.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 load;
  logic [WIDTH-1:0]     Mplier;
  logic [WIDTH-1:0]     Mcand;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic [2*WIDTH:0]     ACC;
  logic [1:0]           state;

  modport master (
    output load, Mplier, Mcand,
    input  product, done, ACC, state
  );

  modport slave (
    input  load, Mplier, Mcand,
    output product, done, ACC, state
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier.
// The multiplier operand is placed in the low half of the accumulator. Each
// iteration conditionally adds the multiplicand into the high half and then
// shifts the whole accumulator right by one.
//
//  state | meaning
//  IDLE  | waiting for load; no valid product yet
//  ADD   | add mcand into ACC high part when ACC[0] is set
//  SHIFT | logical right shift of ACC; last shift latches product
//  DONE  | product valid, done high; load restarts
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // State and datapath registers; reset aborts any run without writing a result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath updates. Load is honoured only in IDLE and DONE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.load) begin
          acc_d   = {{(WIDTH + 1){1'b0}}, bus.Mplier};
          mcand_d = bus.Mcand;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (acc_q[0]) begin
          acc_d[2*WIDTH:WIDTH] = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          product_d = acc_q[2*WIDTH:1];
          state_d   = DONE;
        end else begin
          state_d = ADD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.product = product_q;
  assign bus.ACC     = acc_q;
  assign bus.state   = state_q;
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with hand-computed expected values.
module tb_shift_add_multiplier;

  logic clock = 1'b0;
  logic reset;
  int   compared = 0;
  int   failed   = 0;

  shift_add_multiplier_if #(.WIDTH(8)) bus ();

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts one load, then waits (bounded) for done. The load edge counts as
  // edge 1, so a complete run takes 17 edges.
  task automatic run_op(input string tag, input logic [7:0] mp, input logic [7:0] mc,
                        input logic [15:0] exp_prod, input logic [15:0] prev_prod);
    int n;
    bus.Mplier = mp;
    bus.Mcand  = mc;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    chk({tag, "_state_after_load"}, 32'(bus.state), 32'd1);
    chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
    chk({tag, "_product_held"}, 32'(bus.product), 32'(prev_prod));
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd17);
    chk({tag, "_product"}, 32'(bus.product), 32'(exp_prod));
    chk({tag, "_state_done"}, 32'(bus.state), 32'd3);
    chk({tag, "_acc"}, 32'(bus.ACC), {16'd0, exp_prod});
  endtask

  // Watchdog in case the clock or a wait stalls unexpectedly.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int n;
    reset      = 1'b1;
    bus.load   = 1'b0;
    bus.Mplier = 8'h00;
    bus.Mcand  = 8'h00;
    tick();
    tick();
    chk("rst_acc", 32'(bus.ACC), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_hold", 32'(bus.state), 32'd0);

    run_op("ae_x_01", 8'hAE, 8'h01, 16'h00AE, 16'h0000);
    run_op("ff_x_ff", 8'hFF, 8'hFF, 16'hFE01, 16'h00AE);
    run_op("00_x_5a", 8'h00, 8'h5A, 16'h0000, 16'hFE01);

    tick(); tick();
    chk("done_hold_state", 32'(bus.state), 32'd3);
    chk("done_hold_done", 32'(bus.done), 32'd1);

    // 0x0D * 0x0B with load toggled and operands changed mid-run.
    bus.Mplier = 8'h0D;
    bus.Mcand  = 8'h0B;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    n = 1;
    tick(); n++;
    chk("midrun_first_add_acc", 32'(bus.ACC), 32'h00B0D);
    chk("midrun_first_add_state", 32'(bus.state), 32'd2);
    tick(); n++;
    bus.load   = 1'b1;
    bus.Mplier = 8'hFF;
    bus.Mcand  = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tick(); n++;
      chk("midrun_no_restart", 32'(bus.state == 2'd1 || bus.state == 2'd2), 32'd1);
      bus.load = ~bus.load;
    end
    bus.load = 1'b0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("midrun_latency", 32'(n), 32'd17);
    chk("midrun_product", 32'(bus.product), 32'h008F);

    // Reset during a run aborts it.
    bus.Mplier = 8'h55;
    bus.Mcand  = 8'h33;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_acc", 32'(bus.ACC), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    tick();
    chk("abort_stays_idle", 32'(bus.state), 32'd0);

    run_op("02_x_04", 8'h02, 8'h04, 16'h0008, 16'h0000);
    run_op("03_x_07", 8'h03, 8'h07, 16'h0015, 16'h0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
